mailbox_irq_ctrl: RTL

//  Sits downstream of the IPC mailbox, one instance per hart side.

---
 rtl/mailbox_irq_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mailbox_irq_ctrl.sv
// mailbox_irq_ctrl: conditions a mailbox msg_present level into a PLIC
// interrupt with enable, level/pulse mode, sticky W1C pending and a
// programmable holdoff that coalesces bursts of mailbox traffic.
// Configured through a zero-wait-state APB slave on pclk.
// Optional feature macro: MAILBOX_IRQ_COUNT_EN adds the saturating
// FIRE-entry counter at 0x10; without it 0x10 reads 0 and ignores writes.
//
// Handshake: an APB transfer is accepted in the access phase
// (psel & penable); pready is always 1, so every access phase completes
// on the pclk edge that ends it. prdata is combinational from the current
// register state and is only driven during a read (psel & ~pwrite).
module mailbox_irq_ctrl #(
    parameter int          HOLDOFF_W     = 16,
    parameter int unsigned HOLDOFF_RESET = 0,
    parameter int          CNT_W         = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic [5:0]  paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        msg_present,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [5:0] ADDR_CTRL    = 6'h00;
    localparam logic [5:0] ADDR_HOLDOFF = 6'h04;
    localparam logic [5:0] ADDR_STATUS  = 6'h08;
    localparam logic [5:0] ADDR_ACK     = 6'h0C;
    localparam logic [5:0] ADDR_COUNT   = 6'h10;

    state_t                 state_q, state_d;
    logic                   ctrl_en, ctrl_mode;
    logic [HOLDOFF_W-1:0]   holdoff_q;
    logic [HOLDOFF_W-1:0]   cnt_q;
    logic                   pending_q;
    logic                   msg_q;
    logic                   rise;
    logic                   wr_en;
    logic                   ack_clr;
    logic                   auto_ack;
    logic                   load_cnt;

    assign pready  = 1'b1;
    assign pslverr = 1'b0;

    assign wr_en   = psel & penable & pwrite;
    assign ack_clr = wr_en & (paddr == ADDR_ACK) & pwdata[0];
    assign rise    = msg_present & ~msg_q;

    // Bits of the write bus that no register stores.
    logic unused_pwdata;
    assign unused_pwdata = ^pwdata;

    // Configuration registers written by APB.
    always_ff @(posedge pclk) begin
        if (preset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 1'b0;
            holdoff_q <= HOLDOFF_W'(HOLDOFF_RESET);
        end else if (wr_en) begin
            if (paddr == ADDR_CTRL) begin
                ctrl_en   <= pwdata[0];
                ctrl_mode <= pwdata[1];
            end
            if (paddr == ADDR_HOLDOFF) begin
                holdoff_q <= pwdata[HOLDOFF_W-1:0];
            end
        end
    end

    // Edge register and sticky pending bit; a new rise wins over a clear.
    always_ff @(posedge pclk) begin
        if (preset) begin
            msg_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            msg_q <= msg_present;
            if (rise && ctrl_en) begin
                pending_q <= 1'b1;
            end else if (ack_clr || auto_ack) begin
                pending_q <= 1'b0;
            end
        end
    end

    // FSM state, holdoff counter and registered interrupt output.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            irq     <= 1'b0;
        end else begin
            state_q <= state_d;
            irq     <= (state_q == ST_FIRE);
            if (load_cnt) begin
                cnt_q <= holdoff_q;
            end else if (state_q == ST_HOLD && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Next-state logic: fire on enabled pending, hold off after each fire.
    always_comb begin
        state_d  = state_q;
        auto_ack = 1'b0;
        load_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en && pending_q) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end else if (ctrl_mode) begin
                    state_d  = ST_HOLD;
                    auto_ack = 1'b1;
                    load_cnt = 1'b1;
                end else if (ack_clr) begin
                    state_d  = ST_HOLD;
                    load_cnt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MAILBOX_IRQ_COUNT_EN
    logic [CNT_W-1:0] count_q;
    logic             fire_entry;

    assign fire_entry = (state_q == ST_IDLE) && (state_d == ST_FIRE);

    // Saturating count of FIRE entries; any write to COUNT clears it.
    always_ff @(posedge pclk) begin
        if (preset) begin
            count_q <= '0;
        end else if (wr_en && paddr == ADDR_COUNT) begin
            count_q <= '0;
        end else if (fire_entry && count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + 1'b1;
        end
    end
`endif

    // Combinational read decode; anything unmapped reads 0.
    always_comb begin
        prdata = 32'd0;
        if (psel && !pwrite) begin
            case (paddr)
                ADDR_CTRL:    prdata = {30'd0, ctrl_mode, ctrl_en};
                ADDR_HOLDOFF: prdata = 32'(holdoff_q);
                ADDR_STATUS:  prdata = {28'd0, state_q, pending_q, msg_present};
`ifdef MAILBOX_IRQ_COUNT_EN
                ADDR_COUNT:   prdata = 32'(count_q);
`endif
                default:      prdata = 32'd0;
            endcase
        end
    end

endmodule
